// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port, the data port and the shared memory bus handled by
// mem_port_arbiter.
//   slave  : view taken by the arbiter (requests and mem_rdata in,
//            completions, stalls and the mem_* bus out)
//   master : view taken by the requesters and the memory (the reverse)
// Signals:
//   if_req/if_addr            fetch read request, held until if_ready
//   if_rdata/if_ready         fetch data and its one-cycle completion pulse
//   if_stall                  fetch pipeline register must hold
//   dm_req/dm_we/dm_addr/dm_wdata   data load/store request, held until dm_ready
//   dm_rdata/dm_ready         load data and its one-cycle completion pulse
//   dm_stall                  memory stage must hold
//   mem_en/mem_we/mem_addr/mem_wdata  shared memory access bus
//   mem_rdata                 memory read data, valid MEM_LAT cycles after mem_en rises
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              if_stall;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic              dm_stall;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ready, if_stall,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_rdata, dm_ready, dm_stall,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ready, if_stall,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_rdata, dm_ready, dm_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between the fetch stage (read-only) and the
// memory stage (load/store). Each access is serialised through an
// IDLE -> BUSY -> DONE sequence: the grant is registered, the memory bus is
// held for MEM_LAT cycles, then the owner receives a one-cycle ready pulse.
// One access completes every MEM_LAT+2 cycles.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   mem_port_arbiter_if.slave (fetch port, data port, memory bus)
//   conflict_cnt [15:0]  (ARB_PERF_CNT_EN only) cycles with both ports
//                        stalled, saturating
//   starve_cnt   [7:0]   (ARB_PERF_CNT_EN only) fetch grants forced by the
//                        data streak limit, saturating
//
// Optional feature macro: ARB_PERF_CNT_EN (adds the two counters above).
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 16,
    parameter int MEM_LAT       = 2,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]         conflict_cnt,
    output logic [7:0]          starve_cnt
`endif
);

    localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg;
    logic [3:0]          cnt_reg;
    logic [STREAK_W-1:0] streak_reg;
    logic [STREAK_W-1:0] streak_next;
    logic                owner_dm_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic                mem_en_reg;
    logic                mem_we_reg;
    logic                if_ready_reg;
    logic                dm_ready_reg;
    logic [DATA_W-1:0]   if_rdata_reg;
    logic [DATA_W-1:0]   dm_rdata_reg;

    logic                streak_ok;
    logic                grant_dm;
    logic                grant_if;
    logic                if_stall;
    logic                dm_stall;

    // Data wins unless fetch is waiting and the data streak is exhausted.
    assign streak_ok   = streak_reg < STREAK_MAX;
    assign grant_dm    = bus.dm_req & (~bus.if_req | streak_ok);
    assign grant_if    = bus.if_req & ~grant_dm;
    // The streak only grows while fetch is actually being held off.
    assign streak_next = bus.if_req ? streak_reg + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            streak_reg   <= '0;
            owner_dm_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            mem_en_reg   <= 1'b0;
            mem_we_reg   <= 1'b0;
            if_ready_reg <= 1'b0;
            dm_ready_reg <= 1'b0;
            if_rdata_reg <= '0;
            dm_rdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_dm) begin
                        owner_dm_reg <= 1'b1;
                        addr_reg     <= bus.dm_addr;
                        mem_we_reg   <= bus.dm_we;
                        wdata_reg    <= bus.dm_wdata;
                        streak_reg   <= streak_next;
                        mem_en_reg   <= 1'b1;
                        cnt_reg      <= CNT_INIT;
                        state_reg    <= BUSY;
                    end else if (grant_if) begin
                        owner_dm_reg <= 1'b0;
                        addr_reg     <= bus.if_addr;
                        mem_we_reg   <= 1'b0;
                        wdata_reg    <= '0;
                        streak_reg   <= '0;
                        mem_en_reg   <= 1'b1;
                        cnt_reg      <= CNT_INIT;
                        state_reg    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg == 4'd0) begin
                        // Last latency cycle: read data is valid now.
                        if (!mem_we_reg) begin
                            if (owner_dm_reg) begin
                                dm_rdata_reg <= bus.mem_rdata;
                            end else begin
                                if_rdata_reg <= bus.mem_rdata;
                            end
                        end
                        if (owner_dm_reg) begin
                            dm_ready_reg <= 1'b1;
                        end else begin
                            if_ready_reg <= 1'b1;
                        end
                        mem_en_reg <= 1'b0;
                        mem_we_reg <= 1'b0;
                        state_reg  <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    if_ready_reg <= 1'b0;
                    dm_ready_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign if_stall      = bus.if_req & ~if_ready_reg;
    assign dm_stall      = bus.dm_req & ~dm_ready_reg;

    assign bus.if_stall  = if_stall;
    assign bus.dm_stall  = dm_stall;
    assign bus.if_ready  = if_ready_reg;
    assign bus.dm_ready  = dm_ready_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.dm_rdata  = dm_rdata_reg;
    assign bus.mem_en    = mem_en_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] conflict_cnt_reg;
    logic [7:0]  starve_cnt_reg;
    logic        forced_if;

    // An IF grant is "forced" when data was also asking but its streak ran out.
    assign forced_if = (state_reg == IDLE) & bus.if_req & bus.dm_req & ~streak_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt_reg <= '0;
            starve_cnt_reg   <= '0;
        end else begin
            if (if_stall && dm_stall && (conflict_cnt_reg != 16'hFFFF)) begin
                conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
            end
            if (forced_if && (starve_cnt_reg != 8'hFF)) begin
                starve_cnt_reg <= starve_cnt_reg + 8'd1;
            end
        end
    end

    assign conflict_cnt = conflict_cnt_reg;
    assign starve_cnt   = starve_cnt_reg;
`endif

endmodule
